divmmc_mapper: RTL

- Paging controller for the DivMMC overlay in the 48K memory subsystem.
- Snoops Z80 bus cycles and decodes writes to control port 0xE3.
- Runs the automap trap state machine.
- Drives divMap/divRam/divPage into the memory block, plus a write-protect strobe that gates RAM writes to ROM-mapped regions.

---
 rtl/divmmc_mapper.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/divmmc_mapper.sv
// DivMMC paging controller: decodes the control port, runs the automap trap FSM and gates ROM-area writes.
// Optional NMI button support is compiled in with `define DIVMMC_NMI_EN.
module divmmc_mapper #(
  parameter bit         TRAP_3D = 1'b1,
  parameter logic [7:0] PORT    = 8'hE3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuM1,
  input  logic        cpuMreq,
  input  logic        cpuIorq,
  input  logic        cpuWr,
  input  logic [15:0] cpuA,
  input  logic [7:0]  cpuDi,
`ifdef DIVMMC_NMI_EN
  input  logic        nmiButton,
  output logic        cpuNmi,
`endif
  output logic        divMap,
  output logic        divRam,
  output logic [3:0]  divPage,
  output logic        ramWp
);

  typedef enum logic [1:0] {IDLE, PEND_MAP, PEND_UNMAP} trap_state_t;

  trap_state_t state_q, state_d;
  logic       conmem_q, conmem_d;
  logic       mapram_q, mapram_d;
  logic [3:0] page_q, page_d;
  logic       automap_q, automap_d;
  logic       io_wr_q, fetch_q, m1_q;
  logic       div_map_q, div_map_d;
  logic       div_ram_q, div_ram_d;
  logic [3:0] div_page_q, div_page_d;

  logic io_wr, fetch, fetch_start, fetch_end, port_write;
  logic map_hit, unmap_hit, instant_map;
  logic unused_di;

  assign unused_di = ^cpuDi[5:4];

`ifdef DIVMMC_NMI_EN
  logic nmi_btn_q;
  logic nmi_armed_q, nmi_armed_d;
  logic cpu_nmi_q, cpu_nmi_d;
`endif

  always_comb begin
    io_wr       = !cpuIorq && !cpuWr && (cpuA[7:0] == PORT) && cpuM1;
    fetch       = !cpuM1 && !cpuMreq;
    fetch_start = fetch && !fetch_q;
    fetch_end   = cpuM1 && !m1_q;
    port_write  = io_wr && !io_wr_q;
    map_hit     = (cpuA == 16'h0000) || (cpuA == 16'h0008) || (cpuA == 16'h0038) ||
                  (cpuA == 16'h04C6) || (cpuA == 16'h0562);
`ifdef DIVMMC_NMI_EN
    map_hit     = map_hit || ((cpuA == 16'h0066) && nmi_armed_q);
`endif
    unmap_hit   = (cpuA[15:3] == 13'h03FF);
    instant_map = TRAP_3D && fetch_start && (cpuA[15:8] == 8'h3D) && !automap_q;
  end

  always_comb begin
    state_d   = state_q;
    conmem_d  = conmem_q;
    mapram_d  = mapram_q;
    page_d    = page_q;
    automap_d = automap_q;

    if (port_write) begin
      conmem_d = cpuDi[7];
      mapram_d = mapram_q | cpuDi[6];
      page_d   = cpuDi[3:0];
    end

    // Traps are delayed to the end of the fetch so the trapped opcode still comes from the old map.
    case (state_q)
      IDLE: begin
        if (instant_map)
          automap_d = 1'b1;
        else if (fetch_start && map_hit)
          state_d = PEND_MAP;
        else if (fetch_start && unmap_hit && automap_q)
          state_d = PEND_UNMAP;
      end
      PEND_MAP: begin
        if (fetch_end) begin
          automap_d = 1'b1;
          state_d   = IDLE;
        end
      end
      PEND_UNMAP: begin
        if (fetch_end) begin
          automap_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    div_map_d  = conmem_d | automap_d;
    div_ram_d  = mapram_d & !conmem_d;
    div_page_d = page_d;
  end

`ifdef DIVMMC_NMI_EN
  always_comb begin
    nmi_armed_d = nmi_armed_q;
    cpu_nmi_d   = cpu_nmi_q;
    if (nmiButton && !nmi_btn_q && !div_map_q) begin
      nmi_armed_d = 1'b1;
      cpu_nmi_d   = 1'b0;
    end
    if (fetch_start && (cpuA == 16'h0066)) begin
      nmi_armed_d = 1'b0;
      cpu_nmi_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nmi_btn_q   <= 1'b0;
      nmi_armed_q <= 1'b0;
      cpu_nmi_q   <= 1'b1;
    end else begin
      nmi_btn_q   <= nmiButton;
      nmi_armed_q <= nmi_armed_d;
      cpu_nmi_q   <= cpu_nmi_d;
    end
  end

  assign cpuNmi = cpu_nmi_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      conmem_q   <= 1'b0;
      mapram_q   <= 1'b0;
      page_q     <= 4'd0;
      automap_q  <= 1'b0;
      io_wr_q    <= 1'b0;
      fetch_q    <= 1'b0;
      m1_q       <= 1'b1;
      div_map_q  <= 1'b0;
      div_ram_q  <= 1'b0;
      div_page_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      conmem_q   <= conmem_d;
      mapram_q   <= mapram_d;
      page_q     <= page_d;
      automap_q  <= automap_d;
      io_wr_q    <= io_wr;
      fetch_q    <= fetch;
      m1_q       <= cpuM1;
      div_map_q  <= div_map_d;
      div_ram_q  <= div_ram_d;
      div_page_q <= div_page_d;
    end
  end

  assign divMap  = div_map_q;
  assign divRam  = div_ram_q;
  assign divPage = div_page_q;

  // Protects the 48K ROM, the esxdos ROM and bank 3 when it stands in for the ROM under mapram.
  always_comb begin
    ramWp = !cpuMreq && !cpuWr && (
              ((cpuA[15:14] == 2'b00) && !div_map_q) ||
              (div_map_q && (cpuA[15:13] == 3'b000) && (!conmem_q || mapram_q)) ||
              (div_map_q && (cpuA[15:13] == 3'b001) && mapram_q && !conmem_q && (page_q == 4'd3)));
  end

endmodule
